// File: rtl/adder_pkg.sv
// Shared types and defaults for the multi-cycle add/subtract unit.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // True when a WIDTH/CHUNK pair splits into a whole number of slices.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_n.sv
// Combinational CHUNK-bit ripple-carry adder used for the active slice.
module ripple_carry_adder_n #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  // One full adder per bit; carry ripples LSB to MSB.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/multi_cycle_adder.sv
// Sequential add/subtract: one CHUNK-bit slice per clock, LSB first,
// valid/ready handshake on both sides, result held until taken.
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Refuse to elaborate a width that does not split into whole slices.
  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  adder_state_t     r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;
  logic             r_ready;

  logic [WIDTH-1:0] w_b_eff;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Subtraction is A + ~B + 1; the borrow-in inverts into the carry-in.
  assign w_b_eff = i_b ^ {WIDTH{i_sub}};

  ripple_carry_adder_n #(
    .CHUNK(CHUNK)
  ) u_rca (
    .i_a   (r_a[CHUNK-1:0]),
    .i_b   (r_b[CHUNK-1:0]),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_cout(w_cout)
  );

  assign w_last = (r_cnt == CW'(N - 1));

  // New slice enters at the top; after N slices the sum is fully aligned.
  assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));

  // FSM, operand shift registers, accumulator and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid && r_ready) begin
            r_a     <= i_a;
            r_b     <= w_b_eff;
            r_carry <= i_carry_in ^ i_sub;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_cout;
          r_acc   <= w_acc_next;
          if (w_last) begin
            // The top slice of a/b_eff is still in the low bits here.
            r_sum   <= w_acc_next;
            r_cout  <= w_cout;
            r_ovf   <= (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_s[CHUNK-1] != r_a[CHUNK-1]);
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_sum       = r_sum;
  assign o_carry_out = r_cout;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench: three instances (CHUNK=4, 16, 1) with WIDTH=16.
module tb_multi_cycle_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        v_in   [3];
  logic [15:0] a_in   [3];
  logic [15:0] b_in   [3];
  logic        cin_in [3];
  logic        sub_in [3];
  logic        rdy_in [3];
  logic        rdy_out[3];
  logic        vld_out[3];
  logic [15:0] sum_out[3];
  logic        cout_out[3];
  logic        ovf_out[3];

  exp_t sb_q[3][$];
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CH = (gi == 0) ? 4 : ((gi == 1) ? 16 : 1);
    multi_cycle_adder #(
      .WIDTH(16),
      .CHUNK(CH)
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (v_in[gi]),
      .o_ready    (rdy_out[gi]),
      .i_a        (a_in[gi]),
      .i_b        (b_in[gi]),
      .i_carry_in (cin_in[gi]),
      .i_sub      (sub_in[gi]),
      .o_valid    (vld_out[gi]),
      .i_ready    (rdy_in[gi]),
      .o_sum      (sum_out[gi]),
      .o_carry_out(cout_out[gi]),
      .o_overflow (ovf_out[gi])
    );

    // Monitor: compare on take, check hold while backpressured.
    always @(negedge clk) begin
      if (rst_n && vld_out[gi]) begin
        if (sb_q[gi].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut%0d unexpected_result: got sum=%h, required no result", gi, sum_out[gi]);
        end else begin
          exp_t e;
          e = sb_q[gi][0];
          checks++;
          if (sum_out[gi] !== e.sum || cout_out[gi] !== e.cout ||
              ovf_out[gi] !== e.ovf || rdy_out[gi] !== 1'b0) begin
            failures++;
            $display("FAIL dut%0d %s: got sum=%h c=%b v=%b rdy=%b, required sum=%h c=%b v=%b rdy=0",
                     gi, rdy_in[gi] ? "result" : "hold", sum_out[gi], cout_out[gi],
                     ovf_out[gi], rdy_out[gi], e.sum, e.cout, e.ovf);
          end else begin
            $display("dut%0d %s sum=%h c=%b v=%b", gi, rdy_in[gi] ? "take" : "hold",
                     sum_out[gi], cout_out[gi], ovf_out[gi]);
          end
          if (rdy_in[gi]) void'(sb_q[gi].pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Issue one operation on DUT d; call just after a rising edge.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] es,
                       input logic ec, input logic eo, input bit push, input int exp_lat);
    int n;
    int lat;
    v_in[d] = 1'b1; a_in[d] = a; b_in[d] = b; cin_in[d] = cin; sub_in[d] = sub;
    n = 0;
    @(negedge clk);
    while (!rdy_out[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_out[d]) begin
      checks++;
      failures++;
      $display("FAIL dut%0d accept_timeout: o_ready=0, required 1", d);
    end
    @(posedge clk);
    if (push) sb_q[d].push_back('{sum: es, cout: ec, ovf: eo});
    #1;
    v_in[d] = 1'b0;
    $display("dut%0d issue a=%h b=%h cin=%b sub=%b exp=%h", d, a, b, cin, sub, es);
    if (exp_lat > 0) begin
      lat = 1;
      while (!vld_out[d] && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("dut%0d latency", d), 32'(lat), 32'(exp_lat));
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (sb_q[d].size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("dut%0d drain", d), 32'(sb_q[d].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 3; i++) begin
      v_in[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
      cin_in[i] = 1'b0; sub_in[i] = 1'b0; rdy_in[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_ready", 32'(rdy_out[0]), 32'd1);
    chk("reset o_valid", 32'(vld_out[0]), 32'd0);
    chk("reset o_sum", 32'(sum_out[0]), 32'd0);
    chk("reset flags", {30'd0, cout_out[0], ovf_out[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add/sub vectors on CHUNK=4 (latency 5).
    issue(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 5);
    wait_drain(0);
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 5);
    wait_drain(0);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 5);
    wait_drain(0);
    issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, 5);
    wait_drain(0);
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 5);
    wait_drain(0);
    issue(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1, 5);
    wait_drain(0);

    // Backpressure: hold the result for 6 cycles, then take it.
    rdy_in[0] = 1'b0;
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1, 5);
    repeat (6) @(posedge clk);
    #1;
    rdy_in[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("post_take o_ready", 32'(rdy_out[0]), 32'd1);
    chk("post_take o_valid", 32'(vld_out[0]), 32'd0);
    wait_drain(0);

    // Inputs wiggled during RUN must not disturb the latched operation.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      v_in[0] = ~k[0]; a_in[0] = 16'hFFFF ^ 16'(k); sub_in[0] = k[0]; cin_in[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    v_in[0] = 1'b0; sub_in[0] = 1'b0; cin_in[0] = 1'b0;
    wait_drain(0);

    // Reset in the second RUN cycle aborts the operation.
    issue(0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort o_ready", 32'(rdy_out[0]), 32'd1);
    chk("abort o_valid", 32'(vld_out[0]), 32'd0);
    chk("abort o_sum", 32'(sum_out[0]), 32'd0);
    chk("abort flags", {30'd0, cout_out[0], ovf_out[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("after_abort o_valid", 32'(vld_out[0]), 32'd0);
    chk("after_abort o_sum", 32'(sum_out[0]), 32'd0);
    issue(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1, 5);
    wait_drain(0);

    // N=1 and N=16 variants.
    issue(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, 2);
    wait_drain(1);
    issue(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, 17);
    wait_drain(2);
    issue(2, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1, 17);
    wait_drain(2);
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 2);
    wait_drain(1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_adder.md
# multi_cycle_adder

Parametrised, multi-cycle add/subtract unit that computes a WIDTH-bit sum one CHUNK-bit slice per clock, LSB slice first, with a registered carry between slices. It accepts operands over a valid/ready handshake and holds the result until the consumer takes it. It is the sequential, width-scalable successor to the fixed 4-bit ripple-carry adder. It trades latency for a short CHUNK-bit carry chain, so a wide datapath closes timing without a full-width ripple.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: slice width processed per cycle; N = WIDTH/CHUNK slices (N ≥ 1).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operands present.
- o_ready  out  1  unit can accept operands.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_carry_in  in  1  carry in (add) / borrow in (sub).
- i_sub  in  1  0: A+B+cin; 1: A−B−cin.
- o_valid  out  1  result present.
- i_ready  in  1  consumer takes result.
- o_sum  out  WIDTH  result, modulo 2^WIDTH.
- o_carry_out  out  1  raw carry out of MSB (sub: 1 = no borrow).
- o_overflow  out  1  two's-complement overflow.

## Operation
- Effective operands: b_eff = i_b XOR {WIDTH{i_sub}}; c0 = i_carry_in XOR i_sub. Result = i_a + b_eff + c0.
- The FSM has three states: IDLE, RUN and DONE.
- In IDLE: o_ready=1 and o_valid=0. When i_valid && o_ready, latch i_a, b_eff and c0, clear the slice counter and go to RUN.
- In RUN: o_ready=0. Slice k (k = 0..N−1) adds a[k·CHUNK +: CHUNK] + b_eff slice + the carry register, stores the sum slice and updates the carry register. After slice N−1, go to DONE.
- In DONE: o_valid=1 and o_ready=0. On i_ready, go to IDLE.
- A new operand is not accepted in the same cycle the result is taken.
- o_sum, o_carry_out and o_overflow update only on the RUN→DONE transition. They hold their values until the next such transition, including through IDLE.
- o_overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- i_valid, i_a, i_b, i_sub and i_carry_in are ignored outside IDLE. Changing them during RUN has no effect.
- With N = 1, RUN lasts exactly one cycle.

## Timing
- Reset (async assert, sync deassert as seen by the FSM):
  - State → IDLE.
  - o_ready=1, o_valid=0.
  - o_sum=0, o_carry_out=0, o_overflow=0.
  - Internal counter and carry cleared.
- Reset mid-RUN or mid-DONE aborts the operation. No result is presented.
- Latency: o_valid rises N+1 cycles after the acceptance edge. This is one cycle later than the number of RUN cycles; see Test plan for concrete counts.
- Minimum initiation interval with i_ready tied high: N+2 cycles.
- Backpressure: while o_valid && !i_ready, all outputs are held stable for any number of cycles.
- The slice counter is ⌈log2 N⌉ bits wide (min 1) and saturates by FSM exit, never by wrap-around.

## Structure
- The shared package `adder_pkg` contains:
  - the `adder_state_t` enum {IDLE, RUN, DONE};
  - the localparams DEFAULT_WIDTH=16 and DEFAULT_CHUNK=4;
  - the elaboration check that WIDTH % CHUNK == 0.
- Sub-module `ripple_carry_adder_n` #(CHUNK): a combinational CHUNK-bit ripple adder (a, b, cin → s, cout), instantiated once for the active slice.
- The top level holds the FSM, operand registers (shifted right by CHUNK each RUN cycle), sum accumulator and carry register.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.

- Reset, then 0x0000+0x0000, cin=0, sub=0 → o_valid 5 cycles after acceptance; sum 0x0000, carry 0, ovf 0; o_ready=1 throughout reset.
- 0xFFFF+0x0001, cin=0 → sum 0x0000, carry 1, ovf 0. Then 0x7FFF+0x0001 → sum 0x8000, carry 0, ovf 1.
- sub=1: 0x0005−0x0007, cin=0 → sum 0xFFFE, carry 0, ovf 0. 0x8000−0x0001 → sum 0x7FFF, carry 1, ovf 1.
- 0xFFFF+0xFFFF, cin=1 → sum 0xFFFF, carry 1. Hold i_ready=0 for 6 cycles → outputs stable, o_ready=0. Take the result → o_ready=1 one cycle later.
- Toggle i_a and i_valid during RUN → result matches the latched operands. Pulse i_rst_n low in RUN cycle 2 → all outputs at reset values, then a fresh operation completes correctly.
- Repeat 0x1234+0x4321 → 0x5555 with CHUNK=16 (N=1) and CHUNK=1 (N=16) → latencies of 2 and 17 cycles respectively.
